// File: rtl/ddr_20g_pkg.sv
// Shared constants for the 20G DDR packet generator and its checker:
// end-of-packet flag, the encoder value the head counter never emits,
// ADC lane geometry, FSM encodings and small counter helpers.
package ddr_20g_pkg;

  localparam logic [127:0] PKT_END_FLAG = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;
  localparam logic [63:0]  HEAD_SKIP    = 64'h5A5ADEAD_0000FFFF;

  localparam int ADC_LANES   = 16;
  localparam int ADC_LANE_WD = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_DATA = 3'd2,
    ST_TAIL = 3'd3,
    ST_GAP  = 3'd4
  } gen_state_e;

  // Next encoder head value; jumps over HEAD_SKIP so a head half can never
  // alias the end flag. Wraps naturally at 2^64.
  function automatic logic [63:0] enc_next(input logic [63:0] cur);
    logic [63:0] nxt;
    nxt = cur + 64'd1;
    if (nxt == HEAD_SKIP) nxt = nxt + 64'd1;
    return nxt;
  endfunction

  // Saturating 32-bit statistics increment.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ddr_20g_adc_pattern.sv
// ADC word sequencer: holds the running 16-bit adc_word and presents the
// 16-lane pattern for the word that will be current after this cycle's
// advance, so the top can register the next data beat in one step.
module ddr_20g_adc_pattern
  import ddr_20g_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         advance,
  output logic [255:0] next_pattern
);

  logic [ADC_LANE_WD-1:0] adc_word;
  logic [ADC_LANE_WD-1:0] word_nxt;

  // Word after this cycle: steps by one full beat of lanes on each accepted data beat.
  always_comb begin
    word_nxt = advance ? adc_word + ADC_LANE_WD'(ADC_LANES) : adc_word;
  end

  // Running word register; continues across packets, cleared only by reset/soft clear.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   adc_word <= '0;
    else if (clr) adc_word <= '0;
    else          adc_word <= word_nxt;
  end

  // Lane j carries word + j, modulo 2^16.
  always_comb begin
    next_pattern = '0;
    for (int j = 0; j < ADC_LANES; j++) begin
      next_pattern[j*ADC_LANE_WD +: ADC_LANE_WD] = word_nxt + ADC_LANE_WD'(j);
    end
  end

endmodule

// File: rtl/ddr_20g_pkt_gen.sv
// 20G DDR test packet source: head beat, N ADC beats, end-flag beat, idle gap,
// on a 256-bit AXI-Stream master. All stream outputs come straight from flops.
module ddr_20g_pkt_gen
  import ddr_20g_pkg::*;
#(
  parameter int                 DATA_WD     = 256,
  parameter int                 HEAD_WD     = 64,
  parameter int                 LEN_WD      = 16,
  parameter logic [HEAD_WD-1:0] ENC_RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_rst,
  input  logic               cfg_en,
  input  logic [LEN_WD-1:0]  cfg_pkt_len,
  input  logic [LEN_WD-1:0]  cfg_gap,
  input  logic               cfg_err_inj,
  output logic [DATA_WD-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic [31:0]        pkt_cnt,
  output logic [31:0]        err_inj_cnt
);

  gen_state_e         state_q, state_nxt;
  logic [HEAD_WD-1:0] enc_cnt;
  logic [LEN_WD-1:0]  len_q, gap_q, beat_cnt, gap_cnt;
  logic               inj_arm, beat_inj;
  logic [DATA_WD-1:0] next_pattern;

  logic [DATA_WD-1:0] tdata_nxt;
  logic               tvalid_nxt, tlast_nxt, beat_inj_nxt;

  logic accept, hold, inj_take, load_inj, last_data, gap_done, adc_advance;

  assign accept      = m_axis_tvalid & m_axis_tready;
  assign hold        = m_axis_tvalid & ~m_axis_tready;
  assign inj_take    = accept & beat_inj;
  // The beat whose injection is being accepted must not pass the flip on to its successor.
  assign load_inj    = inj_arm & ~inj_take;
  assign last_data   = (beat_cnt == len_q - LEN_WD'(1));
  assign gap_done    = (gap_cnt == gap_q - LEN_WD'(1));
  assign adc_advance = (state_q == ST_DATA) & accept & ~cfg_rst;

  ddr_20g_adc_pattern u_adc_pattern (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (cfg_rst),
    .advance      (adc_advance),
    .next_pattern (next_pattern)
  );

  // State register; soft clear abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state_q <= ST_IDLE;
    else if (cfg_rst) state_q <= ST_IDLE;
    else              state_q <= state_nxt;
  end

  // Next-state: every transition out of a presenting state waits for an accept.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (cfg_en) state_nxt = ST_HEAD;
      ST_HEAD: if (accept) state_nxt = ST_DATA;
      ST_DATA: if (accept && last_data) state_nxt = ST_TAIL;
      ST_TAIL: begin
        if (accept) begin
          if (gap_q == '0) state_nxt = cfg_en ? ST_HEAD : ST_IDLE;
          else             state_nxt = ST_GAP;
        end
      end
      ST_GAP:  if (gap_done) state_nxt = cfg_en ? ST_HEAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output next-values: hold the presented beat until accepted, otherwise load the next one.
  always_comb begin
    tdata_nxt    = m_axis_tdata;
    tvalid_nxt   = m_axis_tvalid;
    tlast_nxt    = m_axis_tlast;
    beat_inj_nxt = beat_inj;
    if (cfg_rst) begin
      tdata_nxt    = '0;
      tvalid_nxt   = 1'b0;
      tlast_nxt    = 1'b0;
      beat_inj_nxt = 1'b0;
    end else if (!hold) begin
      tdata_nxt    = '0;
      tvalid_nxt   = 1'b0;
      tlast_nxt    = 1'b0;
      beat_inj_nxt = 1'b0;
      unique case (state_nxt)
        ST_HEAD: begin
          tvalid_nxt               = 1'b1;
          tdata_nxt[HEAD_WD-1:0]   = enc_cnt;
        end
        ST_DATA: begin
          tvalid_nxt   = 1'b1;
          tdata_nxt    = next_pattern;
          tdata_nxt[0] = next_pattern[0] ^ load_inj;
          beat_inj_nxt = load_inj;
        end
        ST_TAIL: begin
          tvalid_nxt = 1'b1;
          tlast_nxt  = 1'b1;
          tdata_nxt  = {2{PKT_END_FLAG}};
        end
        default: ;
      endcase
    end
  end

  // Stream output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      beat_inj      <= 1'b0;
    end else begin
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tlast  <= tlast_nxt;
      beat_inj      <= beat_inj_nxt;
    end
  end

  // Packet bookkeeping: latched config, head counter, beat/gap counters, inject arm and stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt     <= ENC_RST_VAL;
      len_q       <= LEN_WD'(1);
      gap_q       <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      inj_arm     <= 1'b0;
      pkt_cnt     <= '0;
      err_inj_cnt <= '0;
    end else if (cfg_rst) begin
      enc_cnt     <= ENC_RST_VAL;
      len_q       <= LEN_WD'(1);
      gap_q       <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      inj_arm     <= 1'b0;
      pkt_cnt     <= '0;
      err_inj_cnt <= '0;
    end else begin
      if (state_q == ST_IDLE && cfg_en) begin
        len_q <= (cfg_pkt_len == '0) ? LEN_WD'(1) : cfg_pkt_len;
        gap_q <= cfg_gap;
      end
      if (state_q == ST_HEAD && accept) begin
        enc_cnt  <= enc_next(enc_cnt);
        beat_cnt <= '0;
      end
      if (state_q == ST_DATA && accept) beat_cnt <= beat_cnt + LEN_WD'(1);
      if (state_q == ST_TAIL && accept) begin
        pkt_cnt <= sat_inc(pkt_cnt);
        gap_cnt <= '0;
      end
      if (state_q == ST_GAP) gap_cnt <= gap_cnt + LEN_WD'(1);
      if (inj_take)         inj_arm <= 1'b0;
      else if (cfg_err_inj) inj_arm <= 1'b1;
      if (inj_take) err_inj_cnt <= sat_inc(err_inj_cnt);
    end
  end

endmodule

// File: tb/tb_ddr_20g_pkt_gen.sv
// Directed bench for ddr_20g_pkt_gen: expected beat tables per scenario,
// an accept monitor with a hold-stability check, and a second instance
// started just below the skipped encoder value.
module tb_ddr_20g_pkt_gen;

  typedef enum logic [1:0] {K_HEAD, K_DATA, K_TAIL} kind_e;
  typedef struct {
    kind_e       kind;
    logic [63:0] val;
    int          dcyc;
    bit          flip;
  } vec_t;
  typedef struct {
    logic [255:0] data;
    logic         last;
    int           cyc;
  } beat_t;

  localparam logic [127:0] END_FLAG = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_rst = 1'b0;
  logic         cfg_en = 1'b0;
  logic         cfg_en2 = 1'b0;
  logic         cfg_err_inj = 1'b0;
  logic [15:0]  cfg_pkt_len = '0;
  logic [15:0]  cfg_gap = '0;
  logic         tready_set = 1'b0;
  logic         rnd_rdy = 1'b0;
  bit           rand_en = 1'b0;
  logic         tready;
  logic [255:0] tdata, tdata2;
  logic         tvalid, tlast, tvalid2, tlast2;
  logic [31:0]  pkt_cnt, err_inj_cnt, pkt_cnt2, err_inj_cnt2;

  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  bit           stab_en = 1'b0;
  bit           prev_hold = 1'b0;
  logic [255:0] prev_data = '0;
  logic         prev_last = 1'b0;

  vec_t         vec [64];
  int           nvec = 0;
  beat_t        acc_q[$];
  logic [256:0] q2[$];

  assign tready = rand_en ? rnd_rdy : tready_set;

  always #5 clk = ~clk;

  ddr_20g_pkt_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_rst       (cfg_rst),
    .cfg_en        (cfg_en),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_gap       (cfg_gap),
    .cfg_err_inj   (cfg_err_inj),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .pkt_cnt       (pkt_cnt),
    .err_inj_cnt   (err_inj_cnt)
  );

  ddr_20g_pkt_gen #(.ENC_RST_VAL(64'h5A5ADEAD_0000FFFE)) dut_skip (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_rst       (1'b0),
    .cfg_en        (cfg_en2),
    .cfg_pkt_len   (16'd1),
    .cfg_gap       (16'd0),
    .cfg_err_inj   (1'b0),
    .m_axis_tdata  (tdata2),
    .m_axis_tvalid (tvalid2),
    .m_axis_tlast  (tlast2),
    .m_axis_tready (1'b1),
    .pkt_cnt       (pkt_cnt2),
    .err_inj_cnt   (err_inj_cnt2)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input kind_e k, input logic [63:0] val, input int dcyc, input bit flip);
    vec[nvec].kind = k;
    vec[nvec].val  = val;
    vec[nvec].dcyc = dcyc;
    vec[nvec].flip = flip;
    nvec++;
  endtask

  function automatic logic [255:0] exp_data(input vec_t v);
    logic [255:0] d;
    d = '0;
    case (v.kind)
      K_HEAD:  d[63:0] = v.val;
      K_DATA:  for (int j = 0; j < 16; j++) d[j*16 +: 16] = v.val[15:0] + 16'(j);
      default: d = {END_FLAG, END_FLAG};
    endcase
    d[0] = d[0] ^ v.flip;
    return d;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (acc_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_timeout"}, 256'(acc_q.size() >= n), 256'd1);
  endtask

  task automatic check_run(input int first, input int n, input bit timing, input string tag);
    vec_t v;
    check({tag, "_count"}, 256'(acc_q.size()), 256'(n));
    for (int i = 0; i < n && i < acc_q.size(); i++) begin
      v = vec[first + i];
      check($sformatf("%s_b%0d_data", tag, i), acc_q[i].data, exp_data(v));
      check($sformatf("%s_b%0d_last", tag, i), 256'(acc_q[i].last), 256'(v.kind == K_TAIL));
      if (timing && i > 0 && v.dcyc > 0)
        check($sformatf("%s_b%0d_spacing", tag, i), 256'(acc_q[i].cyc - acc_q[i-1].cyc), 256'(v.dcyc));
    end
  endtask

  task automatic soft_clear();
    stab_en = 1'b0;
    cfg_en  = 1'b0;
    cfg_rst = 1'b1;
    step(1);
    cfg_rst = 1'b0;
    acc_q.delete();
    step(1);
    stab_en = 1'b1;
  endtask

  // Random ready source for the back-pressure run.
  always begin
    @(posedge clk);
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Mid-cycle monitor: hold stability, accepted-beat capture, skip-instance capture.
  always @(negedge clk) begin
    cyc++;
    if (stab_en && prev_hold) begin
      check("hold_valid", 256'(tvalid), 256'd1);
      check("hold_data", tdata, prev_data);
      check("hold_last", 256'(tlast), 256'(prev_last));
    end
    prev_hold = stab_en && tvalid && !tready;
    prev_data = tdata;
    prev_last = tlast;
    if (tvalid && tready) begin
      beat_t b;
      b.data = tdata;
      b.last = tlast;
      b.cyc  = cyc;
      acc_q.push_back(b);
    end
    if (tvalid2 && q2.size() < 8) q2.push_back({tlast2, tdata2});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // len=4 gap=2, three packets: indices 0..17
    for (int p = 0; p < 3; p++) begin
      add_vec(K_HEAD, 64'(p), (p == 0) ? 0 : 3, 1'b0);
      for (int d = 0; d < 4; d++) add_vec(K_DATA, 64'((p*4 + d) * 16), 1, 1'b0);
      add_vec(K_TAIL, 64'd0, 1, 1'b0);
    end
    // inject run, len=2 gap=1: indices 18..25
    add_vec(K_HEAD, 64'd0,  0, 1'b0);
    add_vec(K_DATA, 64'd0,  1, 1'b1);
    add_vec(K_DATA, 64'd16, 1, 1'b0);
    add_vec(K_TAIL, 64'd0,  1, 1'b0);
    add_vec(K_HEAD, 64'd1,  2, 1'b0);
    add_vec(K_DATA, 64'd32, 1, 1'b0);
    add_vec(K_DATA, 64'd48, 1, 1'b0);
    add_vec(K_TAIL, 64'd0,  1, 1'b0);
    // cfg_en drop, len=8: indices 26..35
    add_vec(K_HEAD, 64'd0, 0, 1'b0);
    for (int d = 0; d < 8; d++) add_vec(K_DATA, 64'(d * 16), 1, 1'b0);
    add_vec(K_TAIL, 64'd0, 1, 1'b0);
    // soft clear mid-packet: before (36,37) and after (38,39)
    add_vec(K_HEAD, 64'd1,   0, 1'b0);
    add_vec(K_DATA, 64'd128, 1, 1'b0);
    add_vec(K_HEAD, 64'd0,   0, 1'b0);
    add_vec(K_DATA, 64'd0,   1, 1'b0);

    // Reset state
    rst_n = 1'b0;
    step(3);
    check("rst_tvalid", 256'(tvalid), 256'd0);
    rst_n = 1'b1;
    step(1);
    check("rst_tvalid_rel", 256'(tvalid), 256'd0);
    check("rst_tlast", 256'(tlast), 256'd0);
    check("rst_tdata", tdata, 256'd0);
    check("rst_pkt_cnt", 256'(pkt_cnt), 256'd0);
    check("rst_err_cnt", 256'(err_inj_cnt), 256'd0);
    cfg_en2 = 1'b1;

    // T1: three packets, always ready
    cfg_pkt_len = 16'd4;
    cfg_gap     = 16'd2;
    tready_set  = 1'b1;
    stab_en     = 1'b1;
    cfg_en      = 1'b1;
    @(negedge clk);
    check("t1_valid_before_sample", 256'(tvalid), 256'd0);
    @(negedge clk);
    check("t1_valid_after_sample", 256'(tvalid), 256'd1);
    wait_beats(13, 200, "t1_pkt3_head");
    cfg_en = 1'b0;
    wait_beats(18, 200, "t1_all");
    step(12);
    check("t1_idle_valid", 256'(tvalid), 256'd0);
    check_run(0, 18, 1'b1, "t1");
    check("t1_pkt_cnt", 256'(pkt_cnt), 256'd3);

    // T2: same traffic under random back-pressure
    soft_clear();
    check("t2_clear_pkt_cnt", 256'(pkt_cnt), 256'd0);
    rand_en     = 1'b1;
    cfg_pkt_len = 16'd4;
    cfg_gap     = 16'd2;
    cfg_en      = 1'b1;
    wait_beats(13, 600, "t2_pkt3_head");
    cfg_en = 1'b0;
    wait_beats(18, 600, "t2_all");
    step(12);
    rand_en = 1'b0;
    check("t2_idle_valid", 256'(tvalid), 256'd0);
    check_run(0, 18, 1'b0, "t2");
    check("t2_pkt_cnt", 256'(pkt_cnt), 256'd3);

    // T4: two inject pulses while armed, only the first data beat is corrupted
    soft_clear();
    tready_set  = 1'b1;
    cfg_pkt_len = 16'd2;
    cfg_gap     = 16'd1;
    cfg_err_inj = 1'b1;
    step(1);
    cfg_err_inj = 1'b0;
    step(1);
    cfg_err_inj = 1'b1;
    step(1);
    cfg_err_inj = 1'b0;
    cfg_en      = 1'b1;
    wait_beats(5, 100, "t4_pkt2_head");
    cfg_en = 1'b0;
    wait_beats(8, 100, "t4_all");
    step(8);
    check_run(18, 8, 1'b1, "t4");
    check("t4_err_inj_cnt", 256'(err_inj_cnt), 256'd1);
    check("t4_pkt_cnt", 256'(pkt_cnt), 256'd2);

    // T5: cfg_en dropped during the second data beat of a len=8 packet
    soft_clear();
    cfg_pkt_len = 16'd8;
    cfg_gap     = 16'd3;
    cfg_en      = 1'b1;
    wait_beats(2, 100, "t5_first_data");
    cfg_en = 1'b0;
    wait_beats(10, 100, "t5_all");
    step(20);
    check("t5_idle_valid", 256'(tvalid), 256'd0);
    check_run(26, 10, 1'b1, "t5");
    check("t5_pkt_cnt", 256'(pkt_cnt), 256'd1);

    // T6: soft clear mid-DATA with ready low; counters continue from T5 beforehand
    acc_q.delete();
    cfg_pkt_len = 16'd4;
    cfg_gap     = 16'd0;
    cfg_en      = 1'b1;
    wait_beats(2, 100, "t6_pre");
    tready_set = 1'b0;
    step(1);
    check("t6_held_valid", 256'(tvalid), 256'd1);
    check("t6_pre_pkt_cnt", 256'(pkt_cnt), 256'd1);
    check_run(36, 2, 1'b0, "t6_pre");
    stab_en = 1'b0;
    cfg_rst = 1'b1;
    step(1);
    check("t6_clr_valid", 256'(tvalid), 256'd0);
    check("t6_clr_last", 256'(tlast), 256'd0);
    check("t6_clr_data", tdata, 256'd0);
    check("t6_clr_pkt_cnt", 256'(pkt_cnt), 256'd0);
    check("t6_clr_err_cnt", 256'(err_inj_cnt), 256'd0);
    cfg_rst = 1'b0;
    acc_q.delete();
    tready_set = 1'b1;
    stab_en    = 1'b1;
    wait_beats(2, 100, "t6_post");
    check_run(38, 2, 1'b0, "t6_post");
    cfg_en = 1'b0;
    step(20);

    // T3: encoder skip on the second instance (len=1: H,D,T per packet)
    check("t3_captured", 256'(q2.size() >= 6), 256'd1);
    if (q2.size() >= 6) begin
      check("t3_head0", 256'(q2[0][63:0]), 256'h5A5ADEAD_0000FFFE);
      check("t3_head0_upper", 256'(q2[0][255:64]), 256'd0);
      check("t3_tail_last", 256'(q2[2][256]), 256'd1);
      check("t3_head1", 256'(q2[3][63:0]), 256'h5A5ADEAD_00010000);
      check("t3_data1_lane0", 256'(q2[4][15:0]), 256'd16);
    end
    check("t3_pkt_cnt_moving", 256'(pkt_cnt2 != 32'd0), 256'd1);
    check("t3_err_cnt", 256'(err_inj_cnt2), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
